// File: rtl/stopwatch_controller.sv
// stopwatch_controller: button conditioning and run/pause/lap/overflow sequencer for the stopwatch counter chain.
// Lap counter flops are built only when STOPWATCH_LAP_COUNT_EN is defined; otherwise lap_count is tied to 0.
module stopwatch_controller #(
  parameter int DEBOUNCE_TICKS = 5,
  parameter int LAP_CNT_W      = 4
) (
  input  logic                 CLK_100Hz,
  input  logic                 reset,
  input  logic                 btn_start_stop,
  input  logic                 btn_lap_reset,
  input  logic                 stopwatch_overflow,
  output logic                 count_en,
  output logic                 display_hold,
  output logic                 clear,
  output logic [2:0]           state,
  output logic [LAP_CNT_W-1:0] lap_count
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUNNING  = 3'd1,
    LAP      = 3'd2,
    PAUSED   = 3'd3,
    OVERFLOW = 3'd4
  } state_t;
  state_t     cur, nxt;
  logic [1:0] sync1, sync2, level, press;
  logic [7:0] cnt [2];
  logic       ss, lr, ovf, do_clear;
  assign ss    = press[0];
  assign lr    = press[1];
  assign state = cur;
  // overflow seen while clear is high is the stale flag the clear is still removing
  assign ovf      = stopwatch_overflow && !clear && cur != OVERFLOW;
  assign do_clear = lr && !ovf && (cur == IDLE || cur == PAUSED || cur == OVERFLOW);
  assign nxt = ovf ? OVERFLOW :
               lr  ? (cur == RUNNING ? LAP : cur == LAP ? RUNNING : IDLE) :
               ss  ? ((cur == IDLE || cur == PAUSED) ? RUNNING : cur == OVERFLOW ? OVERFLOW : PAUSED) :
               cur;
  always_ff @(posedge CLK_100Hz or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      press <= '0;
      cnt   <= '{default: '0};
    end else begin
      sync1 <= {btn_lap_reset, btn_start_stop};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == level[i]) cnt[i] <= '0;
        else if (cnt[i] == 8'(DEBOUNCE_TICKS - 1)) begin
          cnt[i]   <= '0;
          level[i] <= sync2[i];
          press[i] <= sync2[i];
        end else cnt[i] <= cnt[i] + 8'd1;
      end
    end
  end
  always_ff @(posedge CLK_100Hz or posedge reset) begin
    if (reset) begin
      cur          <= IDLE;
      count_en     <= 1'b0;
      display_hold <= 1'b0;
      clear        <= 1'b0;
    end else begin
      cur          <= nxt;
      count_en     <= nxt == RUNNING || nxt == LAP;
      display_hold <= nxt == LAP;
      clear        <= do_clear;
    end
  end
`ifdef STOPWATCH_LAP_COUNT_EN
  logic lap_inc;
  assign lap_inc = lr && !ovf && cur == RUNNING;
  always_ff @(posedge CLK_100Hz or posedge reset) begin
    if (reset) lap_count <= '0;
    else if (do_clear) lap_count <= '0;
    else if (lap_inc && lap_count != '1) lap_count <= lap_count + 1'b1;
  end
`else
  assign lap_count = '0;
`endif
endmodule

// File: tb/tb_stopwatch_controller.sv
// tb_stopwatch_controller: random and directed scenarios checked against an event-level model of the stopwatch sequencer.
`timescale 1ns/1ps
module tb_stopwatch_controller;
  localparam int D = 5;
  localparam int W = 4;
`ifdef STOPWATCH_LAP_COUNT_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, b_ss = 1'b0, b_lr = 1'b0, overflow = 1'b0;
  logic count_en, display_hold, clear;
  logic [2:0] state;
  logic [W-1:0] lap_count;
  int errors = 0, checks = 0, clear_seen = 0;
  int m_state = 0, m_laps = 0, m_clears = 0;

  stopwatch_controller #(.DEBOUNCE_TICKS(D), .LAP_CNT_W(W)) dut (
    .CLK_100Hz(clk), .reset(reset), .btn_start_stop(b_ss), .btn_lap_reset(b_lr),
    .stopwatch_overflow(overflow), .count_en(count_en), .display_hold(display_hold),
    .clear(clear), .state(state), .lap_count(lap_count)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (clear === 1'b1) clear_seen++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Event-level model: states 0 idle, 1 running, 2 lap, 3 paused, 4 overflow
  function automatic void model_step(bit ss, bit lr, bit ovf);
    if (ovf && m_state != 4) m_state = 4;
    else if (lr) begin
      if (m_state == 1) begin m_state = 2; m_laps++; end
      else if (m_state == 2) m_state = 1;
      else begin m_state = 0; m_laps = 0; m_clears++; end
    end else if (ss) begin
      if (m_state == 0 || m_state == 3) m_state = 1;
      else if (m_state != 4) m_state = 3;
    end
  endfunction

  function automatic int exp_lap();
    return LAP_ON ? (m_laps > (1 << W) - 1 ? (1 << W) - 1 : m_laps) : 0;
  endfunction

  task automatic do_reset();
    b_ss = 0; b_lr = 0; overflow = 0;
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
    m_state = 0; m_laps = 0;
  endtask

  task automatic press(bit ss, bit lr);
    int hold = D + 1 + int'($urandom_range(0, 5));
    @(negedge clk); b_ss = ss; b_lr = lr;
    repeat (hold) @(negedge clk);
    b_ss = 0; b_lr = 0;
    repeat (D + 4) @(negedge clk);
    model_step(ss, lr, 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({state, count_en, display_hold, clear} !== 6'b0 || lap_count !== '0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d ce=%0b dh=%0b clr=%0b lap=%0d expected all 0",
               state, count_en, display_hold, clear, lap_count);
    end
    reset = 0;
  endtask

  task automatic test_latency();
    @(negedge clk); b_ss = 1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (count_en !== (k >= 8) || state !== (k >= 8 ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL latency_k%0d: got state=%0d ce=%0b expected state=%0d ce=%0b",
                 k, state, count_en, k >= 8, k >= 8);
      end
    end
    repeat (11) @(negedge clk);
    b_ss = 0;
    repeat (D + 4) @(negedge clk);
    model_step(1, 0, 0);
  endtask

  task automatic test_debounce();
    for (int r = 0; r < 3; r++) begin
      @(negedge clk); b_ss = 1;
      repeat (4) @(negedge clk);
      b_ss = 0;
      repeat (D + 3) @(negedge clk);
      checks++;
      if (state !== 3'd0 || count_en !== 1'b0) begin
        errors++;
        $display("FAIL bounce_%0d: got state=%0d ce=%0b expected state=0 ce=0", r, state, count_en);
      end
    end
    test_latency();
  endtask

  task automatic test_sequence();
    bit ss_seq [5] = '{1, 0, 0, 1, 0};
    int st_exp [5] = '{1, 2, 1, 3, 0};
    int lap_exp [5] = '{0, 1, 1, 1, 0};
    int c0;
    do_reset();
    c0 = clear_seen;
    for (int i = 0; i < 5; i++) begin
      press(ss_seq[i], !ss_seq[i]);
      checks++;
      if (state !== 3'(st_exp[i]) || display_hold !== (st_exp[i] == 2) ||
          lap_count !== W'(LAP_ON ? lap_exp[i] : 0) || clear_seen - c0 != (i == 4 ? 1 : 0)) begin
        errors++;
        $display("FAIL seq_step%0d: got state=%0d dh=%0b lap=%0d clears=%0d expected state=%0d dh=%0b lap=%0d clears=%0d",
                 i, state, display_hold, lap_count, clear_seen - c0, st_exp[i], st_exp[i] == 2,
                 LAP_ON ? lap_exp[i] : 0, i == 4);
      end
    end
  endtask

  task automatic lr_until_clear(output bit seen);
    seen = 0;
    @(negedge clk); b_lr = 1;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      seen = clear;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL clear_wait: got no clear pulse expected clear within 30 cycles");
    end
  endtask

  task automatic test_overflow();
    bit seen;
    do_reset();
    press(1, 0);
    @(negedge clk) overflow = 1;
    @(negedge clk);
    model_step(0, 0, 1);
    checks++;
    if (state !== 3'd4 || count_en !== 1'b0) begin
      errors++;
      $display("FAIL ovf_enter: got state=%0d ce=%0b expected state=4 ce=0", state, count_en);
    end
    press(1, 0);
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL ovf_ss_ignored: got state=%0d expected 4", state);
    end
    lr_until_clear(seen);
    checks++;
    if (state !== 3'd0 || count_en !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear_cycle: got state=%0d ce=%0b expected state=0 ce=0", state, count_en);
    end
    @(negedge clk);
    checks++;
    if (clear !== 1'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL ovf_stale: got clr=%0b state=%0d expected clr=0 state=0", clear, state);
    end
    overflow = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL ovf_stays_idle: got state=%0d expected 0", state);
    end
    b_lr = 0;
    repeat (D + 4) @(negedge clk);
    model_step(0, 1, 0);
    press(1, 0);
    @(negedge clk) overflow = 1;
    @(negedge clk);
    model_step(0, 0, 1);
    lr_until_clear(seen);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL ovf_persist: got state=%0d expected 4", state);
    end
    model_step(0, 1, 0);
    model_step(0, 0, 1);
    overflow = 0; b_lr = 0;
    repeat (D + 4) @(negedge clk);
    press(0, 1);
    checks++;
    if (state !== 3'(m_state) || clear_seen != m_clears) begin
      errors++;
      $display("FAIL ovf_exit: got state=%0d clears=%0d expected state=%0d clears=%0d",
               state, clear_seen, m_state, m_clears);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    press(1, 0);
    press(1, 1);
    checks++;
    if (state !== 3'd2 || lap_count !== W'(exp_lap())) begin
      errors++;
      $display("FAIL simul_ss_lr: got state=%0d lap=%0d expected state=2 lap=%0d", state, lap_count, exp_lap());
    end
    press(0, 1);
    @(negedge clk); b_lr = 1;
    repeat (7) @(negedge clk);
    overflow = 1;
    @(negedge clk);
    model_step(0, 1, 1);
    checks++;
    if (state !== 3'd4 || count_en !== 1'b0 || clear !== 1'b0 || lap_count !== W'(exp_lap())) begin
      errors++;
      $display("FAIL simul_ovf_lr: got state=%0d ce=%0b clr=%0b lap=%0d expected state=4 ce=0 clr=0 lap=%0d",
               state, count_en, clear, lap_count, exp_lap());
    end
    overflow = 0;
    repeat (3) @(negedge clk);
    b_lr = 0;
    repeat (D + 4) @(negedge clk);
    press(0, 1);
  endtask

  task automatic test_saturation();
    do_reset();
    press(1, 0);
    for (int i = 0; i < 17; i++) begin
      press(0, 1);
      press(0, 1);
    end
    checks++;
    if (lap_count !== W'(LAP_ON ? 15 : 0) || state !== 3'd1) begin
      errors++;
      $display("FAIL lap_saturate: got lap=%0d state=%0d expected lap=%0d state=1",
               lap_count, state, LAP_ON ? 15 : 0);
    end
    press(1, 0);
    press(0, 1);
    checks++;
    if (lap_count !== '0 || state !== 3'd0) begin
      errors++;
      $display("FAIL lap_cleared: got lap=%0d state=%0d expected lap=0 state=0", lap_count, state);
    end
  endtask

  task automatic test_async_reset();
    int c0;
    do_reset();
    press(1, 0);
    press(0, 1);
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL pre_reset_lap: got state=%0d expected 2", state);
    end
    c0 = clear_seen;
    @(posedge clk); #3 reset = 1;
    #1;
    checks++;
    if ({state, count_en, display_hold, clear} !== 6'b0 || lap_count !== '0) begin
      errors++;
      $display("FAIL async_reset: got state=%0d ce=%0b dh=%0b clr=%0b lap=%0d expected all 0",
               state, count_en, display_hold, clear, lap_count);
    end
    repeat (3) @(negedge clk);
    reset = 0;
    m_state = 0; m_laps = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (clear_seen != c0) begin
      errors++;
      $display("FAIL reset_no_clear: got %0d clear pulses expected 0", clear_seen - c0);
    end
    test_latency();
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 40; it++) begin
      int op = int'($urandom_range(0, 5));
      if (op <= 1) press(1, 0);
      else if (op == 2) press(0, 1);
      else if (op == 3) press(1, 1);
      else if (op == 4) begin
        bit which = 1'($urandom_range(0, 1));
        @(negedge clk); if (which) b_lr = 1; else b_ss = 1;
        repeat (int'($urandom_range(1, D - 1))) @(negedge clk);
        b_ss = 0; b_lr = 0;
        repeat (D + 4) @(negedge clk);
      end else begin
        @(negedge clk) overflow = 1;
        @(negedge clk) overflow = 0;
        repeat (2) @(negedge clk);
        model_step(0, 0, 1);
      end
      checks++;
      if (state !== 3'(m_state) || count_en !== (m_state == 1 || m_state == 2) ||
          display_hold !== (m_state == 2) || lap_count !== W'(exp_lap()) || clear_seen != m_clears) begin
        errors++;
        $display("FAIL random_op%0d_it%0d: got state=%0d ce=%0b dh=%0b lap=%0d clears=%0d expected state=%0d ce=%0b dh=%0b lap=%0d clears=%0d",
                 op, it, state, count_en, display_hold, lap_count, clear_seen, m_state,
                 m_state == 1 || m_state == 2, m_state == 2, exp_lap(), m_clears);
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_sequence();
    test_overflow();
    test_simultaneous();
    test_saturation();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
- Front-end sequencer for the stopwatch counter datapath (centiseconds/seconds/minutes chain).
- Takes two raw push-buttons and the datapath overflow flag.
- Produces run-enable, display-hold and a synchronous clear pulse that drive the counter chain and the display path.
- Runs in the 100 Hz domain; holds the run/pause/lap/overflow state that the counter chain lacks.

Parameters:
- DEBOUNCE_TICKS, 5, consecutive stable synchronised samples needed before a button level is accepted (range 1..255).
- LAP_CNT_W, 4, width of the lap counter (used only with the optional feature).

Ports:
- CLK_100Hz  input  1  system clock, 100 Hz.
- reset  input  1  asynchronous, active-high reset.
- btn_start_stop  input  1  raw start/stop button, active-high, asynchronous to the clock.
- btn_lap_reset  input  1  raw lap/reset button, active-high, asynchronous to the clock.
- stopwatch_overflow  input  1  overflow flag from the counter chain, level.
- count_en  output  1  1 = counters advance.
- display_hold  output  1  1 = display frozen at its last value while counters keep running.
- clear  output  1  one-cycle pulse that clears every counter and the overflow flag.
- state  output  3  encoded FSM state, for debug.
- lap_count  output  LAP_CNT_W  number of laps taken since the last clear.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; count_en = 0, display_hold = 0, clear = 0, lap_count = 0.
  - Synchroniser flops, debounce counters and debounced levels all = 0.
- Input conditioning (per button, identical):
  - 2-flop synchroniser, then a debounce counter.
  - The counter increments while the synchronised sample differs from the debounced level and resets to 0 when they match.
  - When the counter reaches DEBOUNCE_TICKS, the debounced level takes the new value and the counter returns to 0.
  - A press event is a one-cycle registered pulse on a 0->1 change of the debounced level. Releases generate no event.
- Latency: a raw press held steady from cycle 0 gives a press pulse at cycle DEBOUNCE_TICKS+2. The FSM outputs change at cycle DEBOUNCE_TICKS+3.
- FSM states and encodings: IDLE=0, RUNNING=1, LAP=2, PAUSED=3, OVERFLOW=4. All outputs are registered.
- Outputs per state:
  - IDLE: count_en 0, display_hold 0.
  - RUNNING: count_en 1, display_hold 0.
  - LAP: count_en 1, display_hold 1.
  - PAUSED: count_en 0, display_hold 0.
  - OVERFLOW: count_en 0, display_hold 0.
- Transitions (ss = start_stop press, lr = lap_reset press):
  - IDLE: ss -> RUNNING. lr -> clear pulse, stay IDLE.
  - RUNNING: ss -> PAUSED. lr -> LAP, lap_count += 1.
  - LAP: lr -> RUNNING (display releases). ss -> PAUSED (display releases).
  - PAUSED: ss -> RUNNING. lr -> clear pulse, lap_count = 0, go to IDLE.
  - OVERFLOW: ss ignored. lr -> clear pulse, lap_count = 0, go to IDLE.
- Overflow rule: stopwatch_overflow = 1 in any state except OVERFLOW -> OVERFLOW on the next edge. count_en = 0 from that edge.
- Priority when events coincide in one cycle: overflow > lr > ss. A lower-priority event in the same cycle is discarded, not queued.
- clear is high for exactly one cycle, coincident with the transition edge. count_en is 0 during the clear cycle.
- Overflow during clear: if stopwatch_overflow is still 1 on the cycle after clear, it is treated as stale for one cycle. OVERFLOW is re-entered only if it persists 2 cycles after clear.
- lap_count saturates at all-ones; further laps are still taken but the count does not change.
- Reset asserted mid-operation aborts any transition or pending clear; no clear pulse is emitted by reset itself.
- Button held continuously produces exactly one event. A bounce shorter than DEBOUNCE_TICKS cycles produces none.

Optional Feature:
- Macro: STOPWATCH_LAP_COUNT_EN.
- Defined: lap_count is implemented as described, including the saturating increment and clear on reset-to-IDLE.
- Undefined: the lap_count port stays present but is tied to 0, and no lap counter flops are built. LAP/RUNNING/display_hold behaviour is unchanged.

Test Plan:
- Debounce, DEBOUNCE_TICKS=5: btn_start_stop high for 4 cycles then low, repeated 3 times -> state stays 0, count_en stays 0. Then held high 20 cycles -> state = 1 and count_en = 1 exactly at cycle 8 after the rising edge.
- Full sequence: ss, lr, lr, ss, lr -> states 1,2,1,3,0. display_hold = 1 only in state 2. One clear pulse on the final transition. lap_count 1 before clear, 0 after.
- Overflow: in RUNNING, assert stopwatch_overflow -> next edge state = 4, count_en = 0. ss ignored. lr -> one-cycle clear, state = 0. Overflow deasserted the cycle after clear -> state stays 0.
- Simultaneous: ss and lr press pulses in the same cycle in RUNNING -> state = 2 (lr wins). In RUNNING with overflow and lr together -> state = 4, lap_count unchanged.
- Saturation (macro defined, LAP_CNT_W=4): 17 RUNNING->LAP->RUNNING cycles -> lap_count = 15. With the macro undefined, the same stimulus gives lap_count = 0.
- Async reset asserted in LAP mid-cycle -> state = 0, all outputs 0 immediately, no clear pulse. Deassert, then press ss -> RUNNING with normal latency.
